pe_controller: RTL and testbench

- Sequences one `pe` instance through a dot-product job of programmable length. Reads weight/activation pairs from a local operand buffer, feeds them to the PE, waits out the PE pipeline and reports the job result.
- The PE accumulator clears only on reset, so the controller snapshots the accumulator at job start and reports the difference.
- Sits between the layer scheduler (start/done) and the PE/operand buffer.

---
 rtl/pe_controller.sv | 136 +++++++++++++
 tb/tb_pe_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_controller.sv
// Sequences one PE through a dot-product job: streams operand pairs from the local buffer,
// waits out the PE pipeline and reports the accumulator delta since job start.
module pe_controller #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LEN_W      = 10,
  parameter int unsigned PE_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_result,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [3:0]        i_rd_weight,
  input  logic [7:0]        i_rd_activation,
  output logic [3:0]        o_weight,
  output logic [7:0]        o_activation,
  input  logic [31:0]       i_calculated
);

  // Buffer read + operand register + PE pipeline.
  localparam int unsigned DRAIN_CYCLES = PE_LATENCY + 2;
  localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remain;
  logic [DRAIN_W-1:0]  r_drain;
  logic [31:0]         r_baseline;
  logic [31:0]         r_result;
  logic                r_rd_valid;
  logic [3:0]          r_weight;
  logic [7:0]          r_activation;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next_state = (i_length == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        o_rd_en = 1'b1;
        if (r_remain == LEN_W'(1)) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Result is captured on the edge entering DONE so it is valid alongside o_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_drain    <= '0;
      r_baseline <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr     <= i_base_addr;
            r_remain   <= i_length;
            r_baseline <= i_calculated;
            if (i_length == '0) begin
              r_result <= '0;
            end
          end
        end
        ISSUE: begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_remain <= r_remain - LEN_W'(1);
          r_drain  <= DRAIN_W'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (r_drain == '0) begin
            r_result <= i_calculated - r_baseline;
          end else begin
            r_drain <= r_drain - DRAIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Zero operands whenever no read is returning, so the PE adds nothing outside a job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid   <= 1'b0;
      r_weight     <= '0;
      r_activation <= '0;
    end else begin
      r_rd_valid   <= (r_state == ISSUE);
      r_weight     <= r_rd_valid ? i_rd_weight : '0;
      r_activation <= r_rd_valid ? i_rd_activation : '0;
    end
  end

  assign o_rd_addr    = r_addr;
  assign o_result     = r_result;
  assign o_weight     = r_weight;
  assign o_activation = r_activation;

endmodule

// File: tb/tb_pe_controller.sv
// Bench for pe_controller: operand buffer and two-stage PE models, directed and random jobs
// checked against a plain-arithmetic dot-product reference.
module tb_pe_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [9:0]  i_base_addr;
  logic [9:0]  i_length;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_rd_en;
  logic [9:0]  o_rd_addr;
  logic [3:0]  rd_w;
  logic [7:0]  rd_a;
  logic [3:0]  o_weight;
  logic [7:0]  o_activation;
  logic [31:0] pe_acc;

  int checks = 0;
  int failures = 0;

  logic [3:0]  mem_w [1024];
  logic [7:0]  mem_a [1024];
  logic [31:0] pe_prod;
  logic        preload_en = 1'b0;
  logic [31:0] preload_val = '0;
  logic [9:0]  rd_q [$];

  pe_controller #(.ADDR_W(10), .LEN_W(10), .PE_LATENCY(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_start         (i_start),
    .i_base_addr     (i_base_addr),
    .i_length        (i_length),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_result        (o_result),
    .o_rd_en         (o_rd_en),
    .o_rd_addr       (o_rd_addr),
    .i_rd_weight     (rd_w),
    .i_rd_activation (rd_a),
    .o_weight        (o_weight),
    .o_activation    (o_activation),
    .i_calculated    (pe_acc)
  );

  always #5 clk = ~clk;

  // Operand buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (o_rd_en) begin
      rd_w <= mem_w[o_rd_addr];
      rd_a <= mem_a[o_rd_addr];
    end
  end

  // PE stand-in: shift stage then accumulator; accumulator clears only on reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_prod <= '0;
      pe_acc  <= '0;
    end else begin
      pe_prod <= {24'b0, o_activation} << o_weight;
      pe_acc  <= preload_en ? preload_val : pe_acc + pe_prod;
    end
  end

  always @(negedge clk) begin
    if (o_rd_en === 1'b1) rd_q.push_back(o_rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int base, input int len);
    logic [31:0] s = '0;
    for (int i = 0; i < len; i++) begin
      s += {24'b0, mem_a[(base + i) % 1024]} << mem_w[(base + i) % 1024];
    end
    return s;
  endfunction

  task automatic set_pair(input int addr, input int w, input int a);
    mem_w[addr] = 4'(w);
    mem_a[addr] = 8'(a);
  endtask

  // Starts at the next negedge and returns at the negedge of the DONE cycle.
  task automatic do_job(input int base, input int len, input logic [31:0] exp, input bit noise);
    int cyc;
    int exp_lat;
    exp_lat = (len == 0) ? 1 : len + 5;
    @(negedge clk);
    rd_q.delete();
    chk("idle_busy", o_busy, 0);
    i_start = 1'b1;
    i_base_addr = 10'(base);
    i_length = 10'(len);
    @(negedge clk);
    i_start = 1'b0;
    i_base_addr = 10'($urandom);
    i_length = 10'($urandom);
    cyc = 1;
    while (o_done !== 1'b1 && cyc < len + 40) begin
      chk("busy", o_busy, 1);
      if (noise) begin
        i_start = 1'($urandom);
        i_base_addr = 10'($urandom);
        i_length = 10'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    chk("done_seen", o_done, 1);
    chk("latency", cyc, exp_lat);
    chk("result", o_result, exp);
    chk("busy_in_done", o_busy, 1);
    chk("rd_count", rd_q.size(), len);
    for (int i = 0; i < rd_q.size(); i++) begin
      chk("rd_addr", rd_q[i], (base + i) % 1024);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) set_pair(i, 0, 0);
    reset_n = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_length = '0;
    #12;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_result", o_result, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single pair.
    set_pair(0, 2, 5);
    do_job(0, 1, 32'd20, 0);

    // Four pairs.
    set_pair(16, 1, 3); set_pair(17, 0, 7); set_pair(18, 3, 1); set_pair(19, 2, 10);
    do_job(16, 4, 32'd61, 0);

    // Empty job.
    do_job(40, 0, 32'd0, 0);

    // Back-to-back with start noise during the first job.
    set_pair(100, 0, 9);
    do_job(16, 4, 32'd61, 1);
    do_job(100, 1, 32'd9, 0);

    // Address wrap.
    set_pair(1022, 1, 1); set_pair(1023, 2, 2); set_pair(0, 3, 3); set_pair(1, 4, 4);
    do_job(1022, 4, 32'd98, 0);

    // Accumulator wrap.
    @(negedge clk);
    preload_en = 1'b1;
    preload_val = 32'hFFFF_FFF0;
    @(negedge clk);
    preload_en = 1'b0;
    set_pair(300, 2, 4); set_pair(301, 3, 2);
    do_job(300, 2, 32'h20, 0);

    // Reset in the middle of ISSUE.
    for (int i = 200; i < 208; i++) set_pair(i, 1, i);
    @(negedge clk);
    i_start = 1'b1; i_base_addr = 10'd200; i_length = 10'd8;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_result", o_result, 0);
    chk("abort_rd_en", o_rd_en, 0);
    chk("abort_rd_addr", o_rd_addr, 0);
    chk("abort_weight", o_weight, 0);
    chk("abort_act", o_activation, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", o_done, 0);
    end
    do_job(200, 8, model(200, 8), 0);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      int b;
      int n;
      b = int'($urandom_range(0, 1023));
      n = int'($urandom_range(0, 20));
      for (int i = 0; i < n; i++) begin
        set_pair((b + i) % 1024, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      end
      do_job(b, n, model(b, n), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
